mux_n_pipe: RTL and testbench

Parametrised N:1, W-bit selection stage with a registered output and a valid/ready handshake, backed by a two-entry skid buffer. Successor to the fixed-width 2:1/4:1/8:1 datapath muxes: one block covers any source count and width. Used wherever a pipeline stage must pick one of several operand/result sources and hold the result across back-pressure (ALU result select, forwarding select, write-back select).

---
 rtl/mux_pkg.sv | 18 +
 rtl/mux_n_1.sv | 19 +
 rtl/mux_n_pipe.sv | 118 +++++++++++
 tb/tb_mux_n_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared state encoding and parameter limits for the mux_n_pipe slice.
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } mux_state_e;

  localparam int MUX_MAX_NUM_IN = 16;
  localparam int MUX_MAX_WIDTH  = 128;

  function automatic bit mux_params_ok(input int width, input int num_in);
    return (width >= 1) && (width <= MUX_MAX_WIDTH) &&
           (num_in >= 2) && (num_in <= MUX_MAX_NUM_IN);
  endfunction

endpackage

// File: rtl/mux_n_1.sv
// rtl/mux_n_1.sv - combinational N:1 W-bit selector; out-of-range select yields zero.
module mux_n_1 #(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 8,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] d,
  output logic [WIDTH-1:0]        y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) y = d[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// rtl/mux_n_pipe.sv - registered N:1 select stage with valid/ready and a two-entry skid buffer.
// Optional MUX_SEL_CHECK_EN adds a sticky out-of-range-select flag.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 8,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] d,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    sel_err
);

  if (!mux_params_ok(WIDTH, NUM_IN)) begin : g_bad_params
    $error("mux_n_pipe: WIDTH must be 1..%0d and NUM_IN 2..%0d", MUX_MAX_WIDTH, MUX_MAX_NUM_IN);
  end

  mux_state_e       state, state_next;
  logic [WIDTH-1:0] main_data, skid_data, sel_data;
  logic [SEL_W-1:0] main_sel, skid_sel;
  logic             accept, drain;
  logic             load_main_in, load_main_skid, load_skid;

  mux_n_1 #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_sel (
    .sel (sel),
    .d   (d),
    .y   (sel_data)
  );

  // Handshake outputs decode the state register only, so in_ready never sees out_ready.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign out_sel   = main_sel;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      EMPTY: if (accept) begin
        state_next   = ONE;
        load_main_in = 1'b1;
      end
      ONE: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (drain) begin
          state_next = EMPTY;
        end
      end
      TWO: if (drain) begin
        state_next     = ONE;
        load_main_skid = 1'b1;
      end
      default: state_next = EMPTY;
    endcase
    // Flush wins over any same-cycle accept or drain; the accepted entry is dropped.
    if (flush) begin
      state_next     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_data <= '0;
      main_sel  <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= sel_data;
        main_sel  <= sel;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_sel  <= skid_sel;
      end
      if (load_skid) begin
        skid_data <= sel_data;
        skid_sel  <= sel;
      end
    end
  end

`ifdef MUX_SEL_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)                                sel_err <= 1'b0;
    else if (accept && (int'(sel) >= NUM_IN)) sel_err <= 1'b1;
  end
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// tb/tb_mux_n_pipe.sv - directed and random self-checking bench for mux_n_pipe.
module tb_mux_n_pipe;

`ifdef MUX_SEL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  // u0: WIDTH=64, NUM_IN=8
  logic iv0, ir0, fl0, ov0, or0, se0;
  logic [2:0] s0, os0;
  logic [511:0] d0;
  logic [63:0] od0;
  // u1: WIDTH=16, NUM_IN=6
  logic iv1, ir1, fl1, ov1, or1, se1;
  logic [2:0] s1, os1;
  logic [95:0] d1;
  logic [15:0] od1;
  // u2: WIDTH=32, NUM_IN=16
  logic iv2, ir2, fl2, ov2, or2, se2;
  logic [3:0] s2, os2;
  logic [511:0] d2;
  logic [31:0] od2;

  mux_n_pipe #(.WIDTH(64), .NUM_IN(8)) u0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .sel(s0), .d(d0),
    .flush(fl0), .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_sel(os0), .sel_err(se0));
  mux_n_pipe #(.WIDTH(16), .NUM_IN(6)) u1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .sel(s1), .d(d1),
    .flush(fl1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_sel(os1), .sel_err(se1));
  mux_n_pipe #(.WIDTH(32), .NUM_IN(16)) u2 (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .sel(s2), .d(d2),
    .flush(fl2), .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_sel(os2), .sel_err(se2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    tests++; if (ov0 !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b exp 0", ov0); end
    tests++; if (od0 !== 64'h0) begin fails++; $display("FAIL rst_out_data got %h exp 0", od0); end
    tests++; if (os0 !== 3'd0) begin fails++; $display("FAIL rst_out_sel got %0d exp 0", os0); end
    tests++; if (se0 !== 1'b0 || se1 !== 1'b0) begin fails++; $display("FAIL rst_sel_err got %b%b exp 00", se0, se1); end
    reset = 1'b0;
    tick();
    tests++; if (ir0 !== 1'b1 || ir1 !== 1'b1 || ir2 !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b%b%b exp 111", ir0, ir1, ir2); end
  endtask

  task automatic test_back_to_back;
    or0 = 1'b1; iv0 = 1'b1; s0 = 3'd5;
    tick();
    tests++; if (ov0 !== 1'b1 || od0 !== 64'h1005 || os0 !== 3'd5) begin fails++; $display("FAIL b2b_first got v=%b %h/%0d exp v=1 1005/5", ov0, od0, os0); end
    s0 = 3'd2;
    tick();
    tests++; if (ov0 !== 1'b1 || od0 !== 64'h1002 || os0 !== 3'd2) begin fails++; $display("FAIL b2b_second got v=%b %h/%0d exp v=1 1002/2", ov0, od0, os0); end
    s0 = 3'd7;
    tick();
    tests++; if (ov0 !== 1'b1 || od0 !== 64'h1007 || os0 !== 3'd7) begin fails++; $display("FAIL b2b_third got v=%b %h/%0d exp v=1 1007/7", ov0, od0, os0); end
    tests++; if (ir0 !== 1'b1) begin fails++; $display("FAIL b2b_in_ready got %b exp 1", ir0); end
    iv0 = 1'b0;
    tick();
    tests++; if (ov0 !== 1'b0) begin fails++; $display("FAIL b2b_empty got %b exp 0", ov0); end
  endtask

  task automatic test_backpressure;
    or0 = 1'b0; iv0 = 1'b1; s0 = 3'd1;
    tick();
    tests++; if (ov0 !== 1'b1 || od0 !== 64'h1001 || ir0 !== 1'b1) begin fails++; $display("FAIL bp_one got v=%b %h rdy=%b exp v=1 1001 rdy=1", ov0, od0, ir0); end
    s0 = 3'd3;
    tick();
    tests++; if (ir0 !== 1'b0 || od0 !== 64'h1001) begin fails++; $display("FAIL bp_two got rdy=%b %h exp rdy=0 1001", ir0, od0); end
    s0 = 3'd6;  // offered while full: must not be taken
    tick(); tick();
    tests++; if (od0 !== 64'h1001 || os0 !== 3'd1 || ir0 !== 1'b0) begin fails++; $display("FAIL bp_hold got %h/%0d rdy=%b exp 1001/1 rdy=0", od0, os0, ir0); end
    iv0 = 1'b0; or0 = 1'b1;
    tick();
    tests++; if (ov0 !== 1'b1 || od0 !== 64'h1003 || os0 !== 3'd3) begin fails++; $display("FAIL bp_skid_out got v=%b %h/%0d exp v=1 1003/3", ov0, od0, os0); end
    tests++; if (ir0 !== 1'b1) begin fails++; $display("FAIL bp_ready_back got %b exp 1", ir0); end
    tick();
    tests++; if (ov0 !== 1'b0) begin fails++; $display("FAIL bp_drained got %b exp 0", ov0); end
  endtask

  task automatic test_flush;
    or0 = 1'b0; iv0 = 1'b1; s0 = 3'd4;
    tick();
    s0 = 3'd0;
    tick();
    tests++; if (ir0 !== 1'b0) begin fails++; $display("FAIL fl_two got rdy=%b exp 0", ir0); end
    iv0 = 1'b0; fl0 = 1'b1; or0 = 1'b1;
    tick();
    fl0 = 1'b0;
    tests++; if (ov0 !== 1'b0 || ir0 !== 1'b1) begin fails++; $display("FAIL fl_two_flush got v=%b rdy=%b exp v=0 rdy=1", ov0, ir0); end
    tick(); tick();
    tests++; if (ov0 !== 1'b0) begin fails++; $display("FAIL fl_no_leak got %b exp 0", ov0); end
    iv0 = 1'b1; s0 = 3'd2; fl0 = 1'b1;
    tests++; if (ir0 !== 1'b1) begin fails++; $display("FAIL fl_accept_rdy got %b exp 1", ir0); end
    tick();
    iv0 = 1'b0; fl0 = 1'b0;
    tests++; if (ov0 !== 1'b0) begin fails++; $display("FAIL fl_accept_drop got %b exp 0", ov0); end
    iv0 = 1'b1; s0 = 3'd6;
    tick();
    iv0 = 1'b0; fl0 = 1'b1;
    tick();
    fl0 = 1'b0;
    tests++; if (ov0 !== 1'b0) begin fails++; $display("FAIL fl_one_flush got %b exp 0", ov0); end
  endtask

  task automatic test_reset_mid;
    or0 = 1'b0; iv0 = 1'b1; s0 = 3'd7;
    tick();
    s0 = 3'd5;
    tick();
    iv0 = 1'b0;
    tests++; if (ir0 !== 1'b0) begin fails++; $display("FAIL rm_two got rdy=%b exp 0", ir0); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (ov0 !== 1'b0 || od0 !== 64'h0 || os0 !== 3'd0 || ir0 !== 1'b1 || se0 !== 1'b0) begin
      fails++; $display("FAIL rm_outputs got v=%b %h/%0d rdy=%b err=%b exp v=0 0/0 rdy=1 err=0", ov0, od0, os0, ir0, se0);
    end
    or0 = 1'b1;
    tick();
    tests++; if (ov0 !== 1'b0) begin fails++; $display("FAIL rm_stays_empty got %b exp 0", ov0); end
  endtask

  task automatic test_sel_err;
    or1 = 1'b1;
    tests++; if (se1 !== 1'b0) begin fails++; $display("FAIL se_initial got %b exp 0", se1); end
    iv1 = 1'b1; s1 = 3'd6;
    tick();
    iv1 = 1'b0;
    tests++; if (ov1 !== 1'b1 || od1 !== 16'h0 || os1 !== 3'd6) begin fails++; $display("FAIL se_zero_data got v=%b %h/%0d exp v=1 0/6", ov1, od1, os1); end
    tests++; if (se1 !== EXP_ERR) begin fails++; $display("FAIL se_set got %b exp %b", se1, EXP_ERR); end
    iv1 = 1'b1; s1 = 3'd5;
    tick();
    iv1 = 1'b0;
    tests++; if (od1 !== 16'h2005 || os1 !== 3'd5 || se1 !== EXP_ERR) begin fails++; $display("FAIL se_inrange got %h/%0d err=%b exp 2005/5 err=%b", od1, os1, se1, EXP_ERR); end
    fl1 = 1'b1;
    tick();
    fl1 = 1'b0;
    tests++; if (se1 !== EXP_ERR || ov1 !== 1'b0) begin fails++; $display("FAIL se_flush got err=%b v=%b exp err=%b v=0", se1, ov1, EXP_ERR); end
    tick();
    tests++; if (se1 !== EXP_ERR) begin fails++; $display("FAIL se_sticky got %b exp %b", se1, EXP_ERR); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (se1 !== 1'b0) begin fails++; $display("FAIL se_reset got %b exp 0", se1); end
  endtask

  task automatic test_random;
    logic [31:0] qd[$];
    logic [3:0]  qs[$];
    logic [31:0] hold_d, exp_d;
    logic [3:0]  hold_s, exp_s;
    logic        acc, drn, stall;
    for (int c = 0; c < 10000; c++) begin
      iv2 = 1'($urandom_range(0, 1));
      or2 = 1'($urandom_range(0, 1));
      s2  = 4'($urandom_range(0, 15));
      for (int k = 0; k < 16; k++) d2[k*32 +: 32] = $urandom;
      acc   = iv2 && ir2;
      drn   = ov2 && or2;
      stall = ov2 && !or2;
      hold_d = od2;
      hold_s = os2;
      if (drn) begin
        exp_d = (qd.size() != 0) ? qd[0] : 32'hx;
        exp_s = (qs.size() != 0) ? qs[0] : 4'hx;
        tests++; if (qd.size() == 0 || od2 !== exp_d || os2 !== exp_s) begin
          fails++; $display("FAIL rnd_order cyc %0d got %h/%0d exp %h/%0d", c, od2, os2, exp_d, exp_s);
        end
        if (qd.size() != 0) begin
          void'(qd.pop_front());
          void'(qs.pop_front());
        end
      end
      if (acc) begin
        qd.push_back(d2[32*s2 +: 32]);
        qs.push_back(s2);
      end
      tick();
      if (stall) begin
        tests++; if (od2 !== hold_d || os2 !== hold_s) begin fails++; $display("FAIL rnd_stall cyc %0d got %h/%0d exp %h/%0d", c, od2, os2, hold_d, hold_s); end
      end
      tests++; if (ov2 !== (qd.size() != 0) || ir2 !== (qd.size() < 2)) begin
        fails++; $display("FAIL rnd_occupancy cyc %0d got v=%b rdy=%b exp entries=%0d", c, ov2, ir2, qd.size());
      end
    end
    iv2 = 1'b0;
    tests++; if (se2 !== 1'b0 || se0 !== 1'b0) begin fails++; $display("FAIL pow2_no_err got %b%b exp 00", se2, se0); end
  endtask

  initial begin
    reset = 1'b1;
    iv0 = 1'b0; fl0 = 1'b0; or0 = 1'b0; s0 = '0;
    iv1 = 1'b0; fl1 = 1'b0; or1 = 1'b0; s1 = '0;
    iv2 = 1'b0; fl2 = 1'b0; or2 = 1'b0; s2 = '0; d2 = '0;
    for (int k = 0; k < 8; k++) d0[k*64 +: 64] = 64'h1000 + 64'(k);
    for (int k = 0; k < 6; k++) d1[k*16 +: 16] = 16'h2000 + 16'(k);
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_sel_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
